multi_counter_bank: RTL and testbench
=====================================

// Module: multi_counter_bank
// PURPOSE
//   Parametrised bank of NUM_CH independent free-running counters, the next generation of the single 8-bit
//   free-running counter in sub-modules. Adds per-channel enable, clear, load, up/down direction, a wrap or
//   saturate mode and sticky overflow flags. Count state is held in the internal register array `cnt_q` so that
//   top-level logic and benches can probe it hierarchically (whole vector, one bit or a part-select) as well as
//   through the `count` port.
// PARAMETERS
//   NUM_CH    4   number of counter channels (1..16)
//   WIDTH     8   bits per counter (2..32)
//   STEP      1   increment/decrement magnitude per enabled cycle (1..2**WIDTH-1)
//   SATURATE  0   0: wrap modulo 2**WIDTH; 1: clamp at all-ones (up) or zero (down)
// PORTS
//   clk       in   1              clock; all state updates on posedge
//   rst_n     in   1              asynchronous active-low reset
//   en        in   NUM_CH         per-channel count enable
//   dir       in   NUM_CH         per-channel direction: 1 up, 0 down
//   clr       in   NUM_CH         per-channel synchronous clear to zero
//   load      in   NUM_CH         per-channel synchronous load
//   load_val  in   NUM_CH*WIDTH   load values; channel i at [i*WIDTH +: WIDTH]
//   ovf_clr   in   NUM_CH         per-channel clear of the sticky overflow flag
//   count     out  NUM_CH*WIDTH   registered counts; equal to cnt_q, channel i at [i*WIDTH +: WIDTH]
//   ovf       out  NUM_CH         sticky overflow/underflow flags
//   tick      out  NUM_CH         one-cycle pulse, registered, in the cycle after a wrap or saturation event
// BEHAVIOUR
//   Reset: while rst_n is low, all cnt_q, count, ovf and tick are 0, regardless of clk.
//   Per-channel update at posedge. Priority is clr > load > en. Only one action applies per cycle:
//     - clr:  cnt_q <= 0. Not an overflow event.
//     - load: cnt_q <= load_val slice. Not an overflow event.
//     - en && dir:  nxt = cnt_q + STEP, computed at WIDTH+1 bits; carry bit = event.
//     - en && !dir: nxt = cnt_q - STEP; borrow = event.
//     - otherwise: hold.
//   On an event:
//     - SATURATE=0: cnt_q <= nxt[WIDTH-1:0] (modulo wrap).
//     - SATURATE=1: cnt_q <= all-ones (up) or 0 (down).
//     - In both modes: ovf <= 1 and tick <= 1 for that channel in the same edge.
//   Saturated hold also counts as an event: en=1 while already at all-ones (up) or 0 (down) raises tick every cycle.
//   tick is 0 in any cycle without an event.
//   ovf is sticky until ovf_clr. If ovf_clr and a new event occur in the same cycle, ovf stays 1 (set wins).
//   Latency: count, ovf and tick reflect inputs one clock after sampling. No combinational input-to-output path.
//   Channels are fully independent; any mix of simultaneous per-channel controls is legal.
//   rst_n assertion mid-count clears state immediately. The first edge after release behaves as from reset.
// CONFIGURATION
//   MULTI_COUNTER_BANK_SNAPSHOT_EN
//     Defined:
//       - adds snap_req (in, 1), snap_data (out, NUM_CH*WIDTH) and snap_valid (out, 1).
//       - snap_req at edge N: snap_data <= post-update values of all channels from edge N; snap_valid <= 1 for one cycle.
//       - snap_data holds until the next snap_req. Back-to-back requests capture every cycle.
//       - Reset clears snap_data and snap_valid to 0.
//     Undefined: these ports and registers do not exist; the rest of the behaviour is unchanged.
// TESTING
//   1. Reset: rst_n=0 with clk toggling and en=all-ones -> count=0, ovf=0, tick=0. Release: 1 clock later ch0=1 (WIDTH=8, STEP=1).
//   2. Wrap: SATURATE=0, load ch1=8'hFE, en up for 3 clocks -> 8'hFF, 8'h00, 8'h01; tick pulses once on the 8'h00 cycle;
//      ovf[1]=1 stays set until ovf_clr[1].
//   3. Saturate: SATURATE=1, ch2 load 8'h02, dir=0, STEP=1, en for 4 clocks -> 1, 0, 0, 0; tick high on the 3rd and 4th cycles.
//   4. Priority: ch3 asserts clr, load (8'h55) and en in the same cycle -> 0; load and en only -> 8'h55.
//      ovf_clr together with a new event -> ovf stays 1.
//   5. Hierarchical probe: run ch0 from 0 for 200 clocks -> cnt_q[0]=8'hC8, cnt_q[0][7]=1, cnt_q[0][3:0]=4'h8,
//      all matching the count[7:0] port.
//   6. Snapshot (MULTI_COUNTER_BANK_SNAPSHOT_EN): counters running, snap_req for 1 cycle, then reset asserted mid-run
//      -> snap_data equals count of the request edge with snap_valid for 1 cycle; reset zeroes both.

Source files
------------

// File: rtl/multi_counter_bank_if.sv
// Control and status bundle for multi_counter_bank.
// Snapshot signals exist only when MULTI_COUNTER_BANK_SNAPSHOT_EN is defined.
interface multi_counter_bank_if #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8
);
    logic [NUM_CH-1:0]       en;
    logic [NUM_CH-1:0]       dir;
    logic [NUM_CH-1:0]       clr;
    logic [NUM_CH-1:0]       load;
    logic [NUM_CH*WIDTH-1:0] load_val;
    logic [NUM_CH-1:0]       ovf_clr;
    logic [NUM_CH*WIDTH-1:0] count;
    logic [NUM_CH-1:0]       ovf;
    logic [NUM_CH-1:0]       tick;
`ifdef MULTI_COUNTER_BANK_SNAPSHOT_EN
    logic                    snap_req;
    logic [NUM_CH*WIDTH-1:0] snap_data;
    logic                    snap_valid;

    modport master (
        output en, dir, clr, load, load_val, ovf_clr, snap_req,
        input  count, ovf, tick, snap_data, snap_valid
    );
    modport slave (
        input  en, dir, clr, load, load_val, ovf_clr, snap_req,
        output count, ovf, tick, snap_data, snap_valid
    );
`else
    modport master (
        output en, dir, clr, load, load_val, ovf_clr,
        input  count, ovf, tick
    );
    modport slave (
        input  en, dir, clr, load, load_val, ovf_clr,
        output count, ovf, tick
    );
`endif
endinterface

// File: rtl/multi_counter_bank.sv
// Bank of NUM_CH independent up/down counters with clear/load, wrap or saturate, sticky overflow and tick.
// Optional snapshot capture of all channels: define MULTI_COUNTER_BANK_SNAPSHOT_EN.
module multi_counter_bank #(
    parameter int              NUM_CH   = 4,
    parameter int              WIDTH    = 8,
    parameter longint unsigned STEP     = 1,
    parameter int              SATURATE = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    multi_counter_bank_if.slave bus
);
    localparam logic [WIDTH:0]   L_STEP = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] L_ONES = '1;
    localparam bit               L_SAT  = (SATURATE != 0);

    // Kept as a plain unpacked array so it can be probed hierarchically.
    logic [WIDTH-1:0]        cnt_q      [NUM_CH];
    logic [WIDTH-1:0]        w_cnt_next [NUM_CH];
    logic [NUM_CH-1:0]       w_evt;
    logic [NUM_CH*WIDTH-1:0] w_count;
    logic [NUM_CH-1:0]       r_ovf;
    logic [NUM_CH-1:0]       r_tick;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [WIDTH:0]   w_sum;
            logic [WIDTH:0]   w_dif;
            logic [WIDTH-1:0] w_ld;
            logic [WIDTH-1:0] w_up;
            logic [WIDTH-1:0] w_dn;

            // Extra MSB holds carry (up) or borrow (down); either is an overflow event.
            assign w_sum = {1'b0, cnt_q[gi]} + L_STEP;
            assign w_dif = {1'b0, cnt_q[gi]} - L_STEP;
            assign w_ld  = bus.load_val[gi*WIDTH +: WIDTH];
            assign w_up  = (w_sum[WIDTH] && L_SAT) ? L_ONES : w_sum[WIDTH-1:0];
            assign w_dn  = (w_dif[WIDTH] && L_SAT) ? '0     : w_dif[WIDTH-1:0];

            assign w_evt[gi] = !bus.clr[gi] && !bus.load[gi] && bus.en[gi] &&
                               (bus.dir[gi] ? w_sum[WIDTH] : w_dif[WIDTH]);

            assign w_cnt_next[gi] = bus.clr[gi]  ? '0   :
                                    bus.load[gi] ? w_ld :
                                    bus.en[gi]   ? (bus.dir[gi] ? w_up : w_dn) :
                                                   cnt_q[gi];

            assign w_count[gi*WIDTH +: WIDTH] = cnt_q[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
            r_ovf  <= '0;
            r_tick <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= w_cnt_next[i];
            end
            // A new event overrides a simultaneous flag clear.
            r_ovf  <= w_evt | (r_ovf & ~bus.ovf_clr);
            r_tick <= w_evt;
        end
    end

    assign bus.count = w_count;
    assign bus.ovf   = r_ovf;
    assign bus.tick  = r_tick;

`ifdef MULTI_COUNTER_BANK_SNAPSHOT_EN
    logic [NUM_CH*WIDTH-1:0] w_count_next;
    logic [NUM_CH*WIDTH-1:0] r_snap_data;
    logic                    r_snap_valid;

    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_snap
            assign w_count_next[gi*WIDTH +: WIDTH] = w_cnt_next[gi];
        end
    endgenerate

    // Capture the post-update values so the snapshot matches count after the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap_data  <= '0;
            r_snap_valid <= 1'b0;
        end else begin
            if (bus.snap_req) begin
                r_snap_data <= w_count_next;
            end
            r_snap_valid <= bus.snap_req;
        end
    end

    assign bus.snap_data  = r_snap_data;
    assign bus.snap_valid = r_snap_valid;
`endif

endmodule

// File: tb/tb_multi_counter_bank.sv
// Scoreboard bench for multi_counter_bank: a wrapping and a saturating instance share one stimulus stream.
// Snapshot checks are included when MULTI_COUNTER_BANK_SNAPSHOT_EN is defined.
module tb_multi_counter_bank;
    localparam int NC   = 4;
    localparam int W    = 8;
    localparam int MAXV = (1 << W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multi_counter_bank_if #(.NUM_CH(NC), .WIDTH(W)) bw ();
    multi_counter_bank_if #(.NUM_CH(NC), .WIDTH(W)) bs ();

    assign bs.en       = bw.en;
    assign bs.dir      = bw.dir;
    assign bs.clr      = bw.clr;
    assign bs.load     = bw.load;
    assign bs.load_val = bw.load_val;
    assign bs.ovf_clr  = bw.ovf_clr;
`ifdef MULTI_COUNTER_BANK_SNAPSHOT_EN
    assign bs.snap_req = bw.snap_req;
`endif

    multi_counter_bank #(.NUM_CH(NC), .WIDTH(W), .STEP(1), .SATURATE(0)) u_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bw.slave)
    );

    multi_counter_bank #(.NUM_CH(NC), .WIDTH(W), .STEP(1), .SATURATE(1)) u_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bs.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef struct packed {
        logic [1:0][NC*W-1:0] count;
        logic [1:0][NC-1:0]   ovf;
        logic [1:0][NC-1:0]   tick;
`ifdef MULTI_COUNTER_BANK_SNAPSHOT_EN
        logic [1:0][NC*W-1:0] snap_data;
        logic [1:0]           snap_valid;
`endif
    } exp_t;

    exp_t q[$];
    int   m_cnt [2][NC];
    bit   m_ovf [2][NC];
`ifdef MULTI_COUNTER_BANK_SNAPSHOT_EN
    logic [NC*W-1:0] m_snap [2];
`endif

    always @(posedge clk) begin
        exp_t e;
        int   v;
        bit   t;
        e = '0;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NC; i++) begin
                t = 1'b0;
                if (!rst_n) begin
                    m_cnt[d][i] = 0;
                    m_ovf[d][i] = 1'b0;
                end else begin
                    if (bw.clr[i]) begin
                        m_cnt[d][i] = 0;
                    end else if (bw.load[i]) begin
                        m_cnt[d][i] = int'(bw.load_val[i*W +: W]);
                    end else if (bw.en[i]) begin
                        if (bw.dir[i]) begin
                            v = m_cnt[d][i] + 1;
                            if (v > MAXV) begin
                                t = 1'b1;
                                v = (d == 1) ? MAXV : v - (MAXV + 1);
                            end
                        end else begin
                            v = m_cnt[d][i] - 1;
                            if (v < 0) begin
                                t = 1'b1;
                                v = (d == 1) ? 0 : v + (MAXV + 1);
                            end
                        end
                        m_cnt[d][i] = v;
                    end
                    if (t) m_ovf[d][i] = 1'b1;
                    else if (bw.ovf_clr[i]) m_ovf[d][i] = 1'b0;
                end
                e.count[d][i*W +: W] = W'(m_cnt[d][i]);
                e.ovf[d][i]          = m_ovf[d][i];
                e.tick[d][i]         = t;
            end
`ifdef MULTI_COUNTER_BANK_SNAPSHOT_EN
            if (!rst_n) begin
                m_snap[d]        = '0;
                e.snap_valid[d]  = 1'b0;
            end else begin
                if (bw.snap_req) m_snap[d] = e.count[d];
                e.snap_valid[d] = bw.snap_req;
            end
            e.snap_data[d] = m_snap[d];
`endif
        end
        q.push_back(e);
    end

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("wrap_count", 64'(bw.count), 64'(e.count[0]));
            chk("wrap_ovf",   64'(bw.ovf),   64'(e.ovf[0]));
            chk("wrap_tick",  64'(bw.tick),  64'(e.tick[0]));
            chk("sat_count",  64'(bs.count), 64'(e.count[1]));
            chk("sat_ovf",    64'(bs.ovf),   64'(e.ovf[1]));
            chk("sat_tick",   64'(bs.tick),  64'(e.tick[1]));
`ifdef MULTI_COUNTER_BANK_SNAPSHOT_EN
            chk("wrap_snap_data",  64'(bw.snap_data),  64'(e.snap_data[0]));
            chk("wrap_snap_valid", 64'(bw.snap_valid), 64'(e.snap_valid[0]));
            chk("sat_snap_data",   64'(bs.snap_data),  64'(e.snap_data[1]));
            chk("sat_snap_valid",  64'(bs.snap_valid), 64'(e.snap_valid[1]));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle_inputs();
        bw.en = '0; bw.dir = '0; bw.clr = '0; bw.load = '0; bw.ovf_clr = '0; bw.load_val = '0;
`ifdef MULTI_COUNTER_BANK_SNAPSHOT_EN
        bw.snap_req = 1'b0;
`endif
    endtask

    task automatic randomize_inputs();
        bw.en       = NC'($urandom);
        bw.dir      = NC'($urandom);
        bw.load_val = (NC*W)'($urandom);
        for (int i = 0; i < NC; i++) begin
            bw.clr[i]     = ($urandom_range(15) == 0);
            bw.load[i]    = ($urandom_range(15) == 0);
            bw.ovf_clr[i] = ($urandom_range(7) == 0);
        end
`ifdef MULTI_COUNTER_BANK_SNAPSHOT_EN
        bw.snap_req = ($urandom_range(3) == 0);
`endif
    endtask

    function automatic logic [W-1:0] ch(input logic [NC*W-1:0] v, input int i);
        return v[i*W +: W];
    endfunction

    initial begin
        idle_inputs();
        bw.en  = '1;
        bw.dir = '1;

        // Reset with clock running and all channels enabled
        repeat (3) @(negedge clk);
        chk("rst_count", 64'(bw.count), 64'd0);
        chk("rst_ovf",   64'(bw.ovf),   64'd0);
        chk("rst_tick",  64'(bw.tick),  64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ch0", 64'(ch(bw.count, 0)), 64'd1);
        idle_inputs();

        // Wrap on ch1
        bw.load[1] = 1'b1; bw.load_val[1*W +: W] = 8'hFE;
        @(negedge clk);
        bw.load = '0; bw.en[1] = 1'b1; bw.dir[1] = 1'b1;
        @(negedge clk);
        chk("wrap_ff",      64'(ch(bw.count, 1)), 64'hFF);
        chk("wrap_ff_tick", 64'(bw.tick[1]), 64'd0);
        @(negedge clk);
        chk("wrap_00",      64'(ch(bw.count, 1)), 64'h00);
        chk("wrap_00_tick", 64'(bw.tick[1]), 64'd1);
        chk("wrap_00_ovf",  64'(bw.ovf[1]), 64'd1);
        @(negedge clk);
        chk("wrap_01",      64'(ch(bw.count, 1)), 64'h01);
        chk("wrap_01_tick", 64'(bw.tick[1]), 64'd0);
        bw.en = '0;
        @(negedge clk);
        chk("wrap_ovf_sticky", 64'(bw.ovf[1]), 64'd1);
        bw.ovf_clr[1] = 1'b1;
        @(negedge clk);
        chk("wrap_ovf_clr", 64'(bw.ovf[1]), 64'd0);
        bw.ovf_clr = '0;

        // Saturate down on ch2
        bw.load[2] = 1'b1; bw.load_val[2*W +: W] = 8'h02; bw.dir[2] = 1'b0;
        @(negedge clk);
        bw.load = '0; bw.en[2] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("sat_dn_count", 64'(ch(bs.count, 2)), (k == 0) ? 64'd1 : 64'd0);
            chk("sat_dn_tick",  64'(bs.tick[2]),      (k >= 2) ? 64'd1 : 64'd0);
        end
        idle_inputs();

        // Priority on ch3
        bw.clr[3] = 1'b1; bw.load[3] = 1'b1; bw.en[3] = 1'b1; bw.dir[3] = 1'b1;
        bw.load_val[3*W +: W] = 8'h55;
        @(negedge clk);
        chk("prio_clr", 64'(ch(bw.count, 3)), 64'h00);
        bw.clr[3] = 1'b0;
        @(negedge clk);
        chk("prio_load", 64'(ch(bw.count, 3)), 64'h55);
        bw.load_val[3*W +: W] = 8'hFF;
        @(negedge clk);
        bw.load[3] = 1'b0;
        @(negedge clk);
        chk("prio_wrap_ovf", 64'(bw.ovf[3]), 64'd1);
        bw.load[3] = 1'b1;
        @(negedge clk);
        bw.load[3] = 1'b0; bw.ovf_clr[3] = 1'b1;
        @(negedge clk);
        chk("prio_ovf_set_wins", 64'(bw.ovf[3]), 64'd1);
        chk("prio_tick",         64'(bw.tick[3]), 64'd1);
        idle_inputs();

        // Long run on ch0 with hierarchical probe
        bw.clr[0] = 1'b1;
        @(negedge clk);
        bw.clr[0] = 1'b0; bw.en[0] = 1'b1; bw.dir[0] = 1'b1;
        repeat (200) @(negedge clk);
        bw.en = '0;
        chk("probe_word", 64'(u_wrap.cnt_q[0]),      64'hC8);
        chk("probe_bit7", 64'(u_wrap.cnt_q[0][7]),   64'd1);
        chk("probe_lo",   64'(u_wrap.cnt_q[0][3:0]), 64'h8);
        chk("probe_port", 64'(ch(bw.count, 0)),      64'hC8);

`ifdef MULTI_COUNTER_BANK_SNAPSHOT_EN
        // Snapshot while running
        bw.en = '1; bw.dir = '1;
        repeat (5) @(negedge clk);
        bw.snap_req = 1'b1;
        @(negedge clk);
        bw.snap_req = 1'b0;
        repeat (3) @(negedge clk);
        idle_inputs();
`endif

        // Randomized traffic
        for (int k = 0; k < 300; k++) begin
            randomize_inputs();
            @(negedge clk);
        end

        // Asynchronous reset mid-run
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_wrap_count", 64'(bw.count), 64'd0);
        chk("async_rst_sat_count",  64'(bs.count), 64'd0);
        chk("async_rst_ovf",        64'({bw.ovf, bs.ovf}), 64'd0);
        chk("async_rst_tick",       64'({bw.tick, bs.tick}), 64'd0);
`ifdef MULTI_COUNTER_BANK_SNAPSHOT_EN
        chk("async_rst_snap", 64'({bw.snap_data, bw.snap_valid}), 64'd0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 50; k++) begin
            randomize_inputs();
            @(negedge clk);
        end
        idle_inputs();
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
